mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
- Four packet sources compete for one downstream channel.
- The block chooses one source, drives the mux select, and locks the grant until that source's packet ends with its last beat.
- A watchdog releases a grant held by a stalled source.
- Sits between the source FIFOs and a single downstream consumer.

---
 rtl/mux4_rr_arbiter_if.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of source-side and downstream-side signals around the
// round-robin arbiter for a shared 4:1 data mux.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [3:0]      last;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [3:0]      src_ready;
    logic [1:0]      sel;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic            busy;
    logic            err;

    modport slave (
        input  req, last, din, out_ready,
        output gnt, src_ready, sel, out_valid,
        output out_data, out_last, busy, err
    );

    modport master (
        output req, last, din, out_ready,
        input  gnt, src_ready, sel, out_valid,
        input  out_data, out_last, busy, err
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 4:1 packet mux; the grant is
// locked per packet and a watchdog releases a stalled source.
module mux4_rr_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    mux4_rr_arbiter_if.slave bus
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [3:0]    gnt, gnt_n;
    logic [1:0]    sel, sel_n;
    logic [1:0]    ptr, ptr_n;
    logic [WW-1:0] wd_cnt, wd_n;
    logic          err, err_n;
    logic [1:0]    pick;
    logic [1:0]    idx;
    logic          xfer;
    logic          wd_fire;

    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.req[idx]) pick = idx;
        end
    end

    assign xfer    = (state == GRANT) & bus.req[sel] & bus.out_ready;
    assign wd_fire = (TIMEOUT != 0) && (state == GRANT)
                     && (wd_cnt == WW'(TIMEOUT));

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        wd_n    = wd_cnt;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                wd_n = '0;
                if (bus.req != 4'b0) begin
                    sel_n   = pick;
                    gnt_n   = 4'b0001 << pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (wd_fire) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0;
                    ptr_n   = sel + 2'd1;
                    wd_n    = '0;
                    err_n   = 1'b1;
                end else if (xfer && bus.last[sel]) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0;
                    ptr_n   = sel + 2'd1;
                    wd_n    = '0;
                end else if (bus.req[sel] || TIMEOUT == 0) begin
                    wd_n = '0;
                end else begin
                    wd_n = wd_cnt + WW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= 4'b0;
            sel    <= 2'd0;
            ptr    <= 2'd0;
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            sel    <= sel_n;
            ptr    <= ptr_n;
            wd_cnt <= wd_n;
            err    <= err_n;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.err       = err;
    assign bus.busy      = (state == GRANT);
    assign bus.out_valid = (state == GRANT) & bus.req[sel];
    assign bus.out_last  = (state == GRANT) & bus.last[sel];
    assign bus.out_data  = bus.din[sel*DW +: DW];
    assign bus.src_ready = gnt & {4{bus.out_ready & (state == GRANT)}};
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus a randomized
// run against a packet-level round-robin reference model.
module tb_mux4_rr_arbiter;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] r, input logic [3:0] l,
                         input logic rdy);
        bus.req       = r;
        bus.last      = l;
        bus.out_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 1'b0);
        bus.din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 1'b1);
        bus.din = 32'hDEADBEEF;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: gnt=%b sel=%0d busy=%b want 0",
                     bus.gnt, bus.sel, bus.busy);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.src_ready !== 4'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b last=%b rdy=%b err=%b want 0",
                     bus.out_valid, bus.out_last, bus.src_ready, bus.err);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        drive(4'b0100, 4'b0, 1'b1);
        bus.din[16 +: 8] = 8'hA1;
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL single_idle: gnt=%b want 0000", bus.gnt);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 ||
            bus.out_data !== 8'hA1 || bus.src_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_b1: gnt=%b sel=%0d data=%h rdy=%b want 0100/2/a1/0100",
                     bus.gnt, bus.sel, bus.out_data, bus.src_ready);
        end
        @(negedge clk);
        bus.din[16 +: 8] = 8'hA2;
        #1;
        n_tests++;
        if (bus.out_data !== 8'hA2 || bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_b2: data=%h last=%b want a2/0",
                     bus.out_data, bus.out_last);
        end
        @(negedge clk);
        bus.din[16 +: 8] = 8'hA3;
        bus.last = 4'b0100;
        #1;
        n_tests++;
        if (bus.out_data !== 8'hA3 || bus.out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_b3: data=%h last=%b want a3/1",
                     bus.out_data, bus.out_last);
        end
        @(negedge clk);
        drive(4'b0, 4'b0, 1'b1);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: gnt=%b busy=%b want 0000/0",
                     bus.gnt, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        @(negedge clk);
        drive(4'hF, 4'hF, 1'b1);
        for (int c = 0; c < 12; c++) begin
            #1;
            exp = (c % 2 == 0) ? 4'b0 : 4'(1 << (((c - 1) / 2) % 4));
            n_tests++;
            if (bus.gnt !== exp) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: gnt=%b want %b", c, bus.gnt, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        drive(4'b0010, 4'b0, 1'b1);
        bus.din[8 +: 8] = 8'h11;
        @(negedge clk);
        @(negedge clk);
        bus.din[8 +: 8] = 8'h22;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (bus.out_data !== 8'h22 || bus.src_ready !== 4'b0 ||
                bus.gnt !== 4'b0010 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: data=%h rdy=%b gnt=%b valid=%b want 22/0000/0010/1",
                         c, bus.out_data, bus.src_ready, bus.gnt, bus.out_valid);
            end
            @(negedge clk);
        end
        drive(4'b0010, 4'b0010, 1'b1);
        #1;
        n_tests++;
        if (bus.src_ready !== 4'b0010 || bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_resume: rdy=%b gnt=%b want 0010/0010",
                     bus.src_ready, bus.gnt);
        end
        @(negedge clk);
        drive(4'b0, 4'b0, 1'b1);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: gnt=%b busy=%b want 0000/0",
                     bus.gnt, bus.busy);
        end
    endtask

    task automatic test_lock();
        do_reset();
        @(negedge clk);
        drive(4'b1000, 4'b0, 1'b1);
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            if (b == 2) bus.req = 4'b1001;
            if (b == 4) bus.last = 4'b1000;
            #1;
            n_tests++;
            if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
                n_fail++;
                $display("FAIL lock_beat%0d: gnt=%b sel=%0d want 1000/3",
                         b, bus.gnt, bus.sel);
            end
        end
        @(negedge clk);
        bus.last = 4'b0;
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL lock_bubble: gnt=%b want 0000", bus.gnt);
        end
        @(negedge clk);
        bus.last = 4'b0001;
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_next: gnt=%b sel=%0d want 0001/0",
                     bus.gnt, bus.sel);
        end
        @(negedge clk);
        drive(4'b0, 4'b0, 1'b1);
    endtask

    task automatic test_watchdog();
        do_reset();
        @(negedge clk);
        drive(4'b0100, 4'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b1001;
        for (int c = 2; c <= 18; c++) begin
            #1;
            n_tests++;
            if (bus.err !== 1'b0 || bus.gnt !== 4'b0100) begin
                n_fail++;
                $display("FAIL wd_wait%0d: err=%b gnt=%b want 0/0100",
                         c, bus.err, bus.gnt);
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (bus.err !== 1'b1 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_fire: err=%b gnt=%b busy=%b want 1/0000/0",
                     bus.err, bus.gnt, bus.busy);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.err !== 1'b0 || bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wd_next: err=%b gnt=%b want 0/1000",
                     bus.err, bus.gnt);
        end
        @(negedge clk);
        drive(4'b0, 4'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        drive(4'b0001, 4'b0001, 1'b1);
        @(negedge clk);
        @(negedge clk);
        drive(4'b0010, 4'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rmid_pre: gnt=%b want 0010", bus.gnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0 || bus.sel !== 2'd0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_clear: gnt=%b sel=%0d valid=%b busy=%b err=%b want 0",
                     bus.gnt, bus.sel, bus.out_valid, bus.busy, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 4'b0, 1'b1);
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.gnt !== 4'b0001 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_restart: gnt=%b err=%b want 0001/0",
                     bus.gnt, bus.err);
        end
        @(negedge clk);
        drive(4'b0, 4'b0, 1'b1);
    endtask

    task automatic test_random();
        int         owner;
        int         ptr;
        int         stall;
        logic       m_err;
        logic [3:0] dead;
        logic [3:0] exp_gnt;
        logic [3:0] exp_rdy;
        logic       exp_valid;
        logic       exp_last;
        do_reset();
        owner = -1;
        ptr   = 0;
        stall = 0;
        m_err = 1'b0;
        dead  = 4'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 29) == 0) dead[k] = ~dead[k];
                bus.req[k]  = !dead[k] && ($urandom_range(0, 3) != 0);
                bus.last[k] = ($urandom_range(0, 2) == 0);
            end
            bus.din       = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_gnt   = (owner < 0) ? 4'b0 : 4'(1 << owner);
            exp_valid = (owner >= 0) && bus.req[owner];
            exp_last  = (owner >= 0) && bus.last[owner];
            exp_rdy   = bus.out_ready ? exp_gnt : 4'b0;
            n_tests++;
            if (bus.gnt !== exp_gnt || bus.busy !== (owner >= 0)) begin
                n_fail++;
                $display("FAIL rand_gnt@%0d: gnt=%b busy=%b want %b/%b",
                         cyc, bus.gnt, bus.busy, exp_gnt, owner >= 0);
            end
            n_tests++;
            if (bus.out_valid !== exp_valid || bus.out_last !== exp_last ||
                bus.src_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_out@%0d: valid=%b last=%b rdy=%b want %b/%b/%b",
                         cyc, bus.out_valid, bus.out_last, bus.src_ready,
                         exp_valid, exp_last, exp_rdy);
            end
            n_tests++;
            if (bus.err !== m_err) begin
                n_fail++;
                $display("FAIL rand_err@%0d: err=%b want %b", cyc, bus.err, m_err);
            end
            if (owner >= 0) begin
                n_tests++;
                if (bus.sel !== 2'(owner) ||
                    bus.out_data !== bus.din[owner*DW +: DW]) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: sel=%0d data=%h want %0d/%h",
                             cyc, bus.sel, bus.out_data, owner,
                             bus.din[owner*DW +: DW]);
                end
            end
            m_err = 1'b0;
            if (owner < 0) begin
                for (int i = 3; i >= 0; i--)
                    if (bus.req[(ptr + i) % 4]) owner = (ptr + i) % 4;
                stall = 0;
            end else if (stall >= TIMEOUT) begin
                ptr   = (owner + 1) % 4;
                owner = -1;
                stall = 0;
                m_err = 1'b1;
            end else if (bus.req[owner] && bus.out_ready && bus.last[owner]) begin
                ptr   = (owner + 1) % 4;
                owner = -1;
                stall = 0;
            end else begin
                stall = bus.req[owner] ? 0 : stall + 1;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req = 4'b0;
        bus.last = 4'b0;
        bus.din = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
